// File: rtl/sc_prog_loader_pkg.sv
// sc_prog_loader_pkg: kind codes, MIPS op/func encodings and loader state encodings
package sc_prog_loader_pkg;
    localparam logic [4:0] K_ADD  = 5'd0;
    localparam logic [4:0] K_SUB  = 5'd1;
    localparam logic [4:0] K_AND  = 5'd2;
    localparam logic [4:0] K_OR   = 5'd3;
    localparam logic [4:0] K_XOR  = 5'd4;
    localparam logic [4:0] K_SLL  = 5'd5;
    localparam logic [4:0] K_SRL  = 5'd6;
    localparam logic [4:0] K_SRA  = 5'd7;
    localparam logic [4:0] K_JR   = 5'd8;
    localparam logic [4:0] K_ADDI = 5'd9;
    localparam logic [4:0] K_ANDI = 5'd10;
    localparam logic [4:0] K_ORI  = 5'd11;
    localparam logic [4:0] K_XORI = 5'd12;
    localparam logic [4:0] K_LW   = 5'd13;
    localparam logic [4:0] K_SW   = 5'd14;
    localparam logic [4:0] K_BEQ  = 5'd15;
    localparam logic [4:0] K_BNE  = 5'd16;
    localparam logic [4:0] K_LUI  = 5'd17;
    localparam logic [4:0] K_J    = 5'd18;
    localparam logic [4:0] K_JAL  = 5'd19;
    localparam int         K_NUM  = 20;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_SRL = 6'h02;
    localparam logic [5:0] FUNC_SRA = 6'h03;
    localparam logic [5:0] FUNC_JR  = 6'h08;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_XOR = 6'h26;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
endpackage

// File: rtl/sc_prog_loader_encode.sv
// sc_inst_encode: combinational kind+fields -> 32-bit MIPS word and validity flag
module sc_inst_encode
    import sc_prog_loader_pkg::*;
(
    input  logic [4:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        valid
);
    // shifts drop rs, jr drops rt/rd/sa, lui drops rs; kinds 20..31 are rejected
    always_comb begin
        word  = '0;
        valid = 1'b1;
        case (kind)
            K_ADD:   word = {OP_RTYPE, rs, rt, rd, sa, FUNC_ADD};
            K_SUB:   word = {OP_RTYPE, rs, rt, rd, sa, FUNC_SUB};
            K_AND:   word = {OP_RTYPE, rs, rt, rd, sa, FUNC_AND};
            K_OR:    word = {OP_RTYPE, rs, rt, rd, sa, FUNC_OR};
            K_XOR:   word = {OP_RTYPE, rs, rt, rd, sa, FUNC_XOR};
            K_SLL:   word = {OP_RTYPE, 5'd0, rt, rd, sa, FUNC_SLL};
            K_SRL:   word = {OP_RTYPE, 5'd0, rt, rd, sa, FUNC_SRL};
            K_SRA:   word = {OP_RTYPE, 5'd0, rt, rd, sa, FUNC_SRA};
            K_JR:    word = {OP_RTYPE, rs, 15'd0, FUNC_JR};
            K_ADDI:  word = {OP_ADDI, rs, rt, imm};
            K_ANDI:  word = {OP_ANDI, rs, rt, imm};
            K_ORI:   word = {OP_ORI, rs, rt, imm};
            K_XORI:  word = {OP_XORI, rs, rt, imm};
            K_LW:    word = {OP_LW, rs, rt, imm};
            K_SW:    word = {OP_SW, rs, rt, imm};
            K_BEQ:   word = {OP_BEQ, rs, rt, imm};
            K_BNE:   word = {OP_BNE, rs, rt, imm};
            K_LUI:   word = {OP_LUI, 5'd0, rt, imm};
            K_J:     word = {OP_J, target};
            K_JAL:   word = {OP_JAL, target};
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/sc_prog_loader.sv
// sc_prog_loader: accepts symbolic instructions, encodes them and writes consecutive imem words
module sc_prog_loader
    import sc_prog_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int BASE   = 0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              full;

    sc_inst_encode u_enc (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .sa     (in_sa),
        .imm    (in_imm),
        .target (in_target),
        .word   (enc_word),
        .valid  (enc_ok)
    );

    assign full       = wptr_q == {ADDR_W{1'b1}};
    assign in_ready   = state_q == S_LOAD;
    assign imem_we    = state_q == S_WRITE;
    assign imem_addr  = wptr_q;
    assign imem_wdata = word_q;
    assign busy       = state_q == S_LOAD || state_q == S_WRITE;
    assign done       = state_q == S_DONE;
    assign err        = state_q == S_ERR;
    assign count      = count_q;

    // next-state: accept in LOAD, write for one cycle, then finish, overflow or continue
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    wptr_d  = ADDR_W'(BASE);
                    count_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    state_d = enc_ok ? S_WRITE : S_ERR;
                    word_d  = enc_ok ? enc_word : word_q;
                    last_d  = enc_ok ? in_last : last_q;
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                wptr_d  = full ? wptr_q : wptr_q + 1'b1;
                state_d = last_q ? S_DONE : full ? S_ERR : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, pointer, counter and held word; reset aborts any in-flight write
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wptr_q  <= ADDR_W'(BASE);
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_sc_prog_loader.sv
// tb_sc_prog_loader: directed scenario tests for sc_prog_loader (ADDR_W=6 and ADDR_W=2 instances)
module tb_sc_prog_loader;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_kind = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;

    logic        in_ready, imem_we, busy, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    logic        in_ready_s, imem_we_s, busy_s, done_s, err_s;
    logic [1:0]  imem_addr_s;
    logic [31:0] imem_wdata_s;
    logic [2:0]  count_s;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sc_prog_loader #(.ADDR_W(6), .BASE(0)) dut (
        .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
        .count(count)
    );

    sc_prog_loader #(.ADDR_W(2), .BASE(0)) dut_s (
        .clock(clock), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .imem_we(imem_we_s),
        .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s), .busy(busy_s), .done(done_s), .err(err_s),
        .count(count_s)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic sel, input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        int n;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!(sel ? in_ready_s : in_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL send_timeout kind=%0d in_ready never rose", k);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (imem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || count !== 7'd0 || imem_wdata !== 32'd0 || imem_addr !== 6'd0) begin
            failures++; $display("FAIL reset_state we=%b busy=%b rdy=%b count=%0d wdata=%h addr=%0d expected all 0", imem_we, busy, in_ready, count, imem_wdata, imem_addr);
        end
        resetn = 1'b1;
        tick();
        do_start();
        send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_we !== 1'b1) begin failures++; $display("FAIL pre_reset_we got=%b expected=1", imem_we); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (imem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || count !== 7'd0) begin
            failures++; $display("FAIL reset_mid_write we=%b busy=%b done=%b err=%b count=%0d expected 0", imem_we, busy, done, err, count);
        end
        #3 resetn = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ready_before_start got=%b expected=0", in_ready); end
    endtask

    task automatic test_rtype();
        do_start();
        send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h00221820) begin
            failures++; $display("FAIL add_write we=%b addr=%0d wdata=%h expected 1/0/00221820", imem_we, imem_addr, imem_wdata);
        end
        tick();
        checks++; if (imem_we !== 1'b0 || in_ready !== 1'b1 || count !== 7'd1) begin
            failures++; $display("FAIL after_add we=%b rdy=%b count=%0d expected 0/1/1", imem_we, in_ready, count);
        end
        send(1'b0, 5'd5, 5'd7, 5'd1, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'h00011100) begin
            failures++; $display("FAIL sll_write we=%b addr=%0d wdata=%h expected 1/1/00011100", imem_we, imem_addr, imem_wdata);
        end
        tick();
    endtask

    task automatic test_itype_jtype();
        pulse_reset();
        do_start();
        send(1'b0, 5'd13, 5'd5, 5'd4, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
        checks++; if (imem_addr !== 6'd0 || imem_wdata !== 32'h8CA40008) begin
            failures++; $display("FAIL lw_write addr=%0d wdata=%h expected 0/8CA40008", imem_addr, imem_wdata);
        end
        tick();
        send(1'b0, 5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'h0C000010) begin
            failures++; $display("FAIL jal_write we=%b addr=%0d wdata=%h expected 1/1/0C000010", imem_we, imem_addr, imem_wdata);
        end
        tick();
        checks++; if (done !== 1'b1 || count !== 7'd2 || busy !== 1'b0 || imem_we !== 1'b0) begin
            failures++; $display("FAIL load_done done=%b count=%0d busy=%b we=%b expected 1/2/0/0", done, count, busy, imem_we);
        end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_held got=%b expected=1", done); end
    endtask

    task automatic test_bad_kind();
        do_start();
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL restart_from_done done=%b rdy=%b expected 0/1", done, in_ready); end
        send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        tick();
        send(1'b0, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_addr !== 6'd1 || imem_wdata !== 32'h00221822) begin
            failures++; $display("FAIL sub_write addr=%0d wdata=%h expected 1/00221822", imem_addr, imem_wdata);
        end
        tick();
        send(1'b0, 5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_we !== 1'b0 || err !== 1'b1 || count !== 7'd2) begin
            failures++; $display("FAIL bad_kind we=%b err=%b count=%0d expected 0/1/2", imem_we, err, count);
        end
        tick();
        checks++; if (imem_we !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL err_held we=%b err=%b expected 0/1", imem_we, err); end
        do_start();
        checks++; if (err !== 1'b0 || count !== 7'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL restart_from_err err=%b count=%0d rdy=%b expected 0/0/1", err, count, in_ready);
        end
        send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd0) begin failures++; $display("FAIL restart_addr we=%b addr=%0d expected 1/0", imem_we, imem_addr); end
        tick();
    endtask

    task automatic test_overflow();
        pulse_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 5'd9, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'd0, 1'b0);
            checks++; if (imem_we_s !== 1'b1 || imem_addr_s !== 2'(i) || imem_wdata_s !== (32'h20010000 | 32'(i))) begin
                failures++; $display("FAIL ovf_write%0d we=%b addr=%0d wdata=%h expected 1/%0d/%h", i, imem_we_s, imem_addr_s, imem_wdata_s, i, 32'h20010000 | 32'(i));
            end
            tick();
        end
        checks++; if (err_s !== 1'b1 || count_s !== 3'd4 || busy_s !== 1'b0) begin
            failures++; $display("FAIL ovf_err err=%b count=%0d busy=%b expected 1/4/0", err_s, count_s, busy_s);
        end
        in_kind = 5'd9; in_imm = 16'd4; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready_s !== 1'b0 || imem_we_s !== 1'b0 || count_s !== 3'd4) begin
                failures++; $display("FAIL ovf_fifth%0d rdy=%b we=%b count=%0d expected 0/0/4", i, in_ready_s, imem_we_s, count_s);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        do_start();
        send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1 || count !== 7'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL start_in_write rdy=%b count=%0d busy=%b expected 1/1/1", in_ready, count, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1 || count !== 7'd1) begin
            failures++; $display("FAIL start_in_load rdy=%b count=%0d expected 1/1", in_ready, count);
        end
        send(1'b0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        checks++; if (imem_addr !== 6'd1 || imem_we !== 1'b1) begin failures++; $display("FAIL continue_addr addr=%0d we=%b expected 1/1", imem_addr, imem_we); end
        in_kind = 5'd1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_sa = 5'd0; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b0 || imem_wdata !== 32'h00221820) begin
            failures++; $display("FAIL pending_hold rdy=%b wdata=%h expected 0/00221820", in_ready, imem_wdata);
        end
        tick();
        checks++; if (in_ready !== 1'b1 || imem_we !== 1'b0) begin failures++; $display("FAIL pending_load rdy=%b we=%b expected 1/0", in_ready, imem_we); end
        tick();
        in_valid = 1'b0;
        checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd2 || imem_wdata !== 32'h00221822) begin
            failures++; $display("FAIL pending_write we=%b addr=%0d wdata=%h expected 1/2/00221822", imem_we, imem_addr, imem_wdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype_jtype();
        test_bad_kind();
        test_overflow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
